// File: rtl/csr_wr_unit_pkg.sv
// Shared types and constants for the machine-mode CSR write unit.
// Holds CSR op/privilege/address enums, the mstatus and mie payload structs,
// mstatus bit positions, the mie legal-bit mask and read-layout helpers.
package csr_wr_unit_pkg;

    localparam int unsigned CSR_W      = 32;
    localparam int unsigned CSR_ADDR_W = 12;

    typedef enum logic [1:0] {
        CSR_OP_READ  = 2'b00,
        CSR_OP_WRITE = 2'b01,
        CSR_OP_SET   = 2'b10,
        CSR_OP_CLEAR = 2'b11
    } csr_op_e;

    typedef enum logic [1:0] {
        PRIV_LVL_U = 2'b00,
        PRIV_LVL_S = 2'b01,
        PRIV_LVL_H = 2'b10,
        PRIV_LVL_M = 2'b11
    } priv_lvl_e;

    typedef enum logic [11:0] {
        CSR_MSTATUS        = 12'h300,
        CSR_MIE            = 12'h304,
        CSR_MTVEC          = 12'h305,
        CSR_MCOUNTINHIBIT  = 12'h320,
        CSR_MHPMEVENT3     = 12'h323,
        CSR_MHPMEVENT31    = 12'h33F,
        CSR_MSCRATCH       = 12'h340,
        CSR_MEPC           = 12'h341,
        CSR_MCAUSE         = 12'h342,
        CSR_MTVAL          = 12'h343,
        CSR_PMPCFG0        = 12'h3A0,
        CSR_PMPCFG3        = 12'h3A3,
        CSR_PMPADDR0       = 12'h3B0,
        CSR_PMPADDR15      = 12'h3BF,
        CSR_MCYCLE         = 12'hB00,
        CSR_MINSTRET       = 12'hB02,
        CSR_MHPMCOUNTER3   = 12'hB03,
        CSR_MHPMCOUNTER31  = 12'hB1F,
        CSR_MCYCLEH        = 12'hB80,
        CSR_MINSTRETH      = 12'hB82,
        CSR_MHPMCOUNTER3H  = 12'hB83,
        CSR_MHPMCOUNTER31H = 12'hB9F,
        CSR_MHARTID        = 12'hF14
    } csr_num_e;

    localparam int unsigned CSR_MSTATUS_MIE_BIT      = 3;
    localparam int unsigned CSR_MSTATUS_MPIE_BIT     = 7;
    localparam int unsigned CSR_MSTATUS_MPP_BIT_LOW  = 11;
    localparam int unsigned CSR_MSTATUS_MPP_BIT_HIGH = 12;
    localparam int unsigned CSR_MSTATUS_MPRV_BIT     = 17;
    localparam int unsigned CSR_MSTATUS_TW_BIT       = 21;

    localparam logic [31:0] CSR_MIE_MASK = 32'h7FFF_0888;

    typedef struct packed {
        logic      mie;
        logic      mpie;
        priv_lvl_e mpp;
        logic      mprv;
        logic      tw;
    } status_t;

    typedef struct packed {
        logic        irq_software;
        logic        irq_timer;
        logic        irq_external;
        logic [14:0] irq_fast;
    } irqs_t;

    // Place stored mstatus fields at their architectural bit positions.
    function automatic logic [CSR_W-1:0] mstatus_to_word(status_t s);
        logic [CSR_W-1:0] w;
        w = '0;
        w[CSR_MSTATUS_MIE_BIT]  = s.mie;
        w[CSR_MSTATUS_MPIE_BIT] = s.mpie;
        w[CSR_MSTATUS_MPP_BIT_HIGH:CSR_MSTATUS_MPP_BIT_LOW] = s.mpp;
        w[CSR_MSTATUS_MPRV_BIT] = s.mprv;
        w[CSR_MSTATUS_TW_BIT]   = s.tw;
        return w;
    endfunction

    // Place stored mie enables at their architectural bit positions.
    function automatic logic [CSR_W-1:0] mie_to_word(irqs_t m);
        logic [CSR_W-1:0] w;
        w = '0;
        w[3]     = m.irq_software;
        w[7]     = m.irq_timer;
        w[11]    = m.irq_external;
        w[30:16] = m.irq_fast;
        return w;
    endfunction

endpackage

// File: rtl/csr_wr_unit_counter.sv
// Performance counter of COUNTER_W bits with 32-bit split write access.
// Ports: clk_i/rst_ni clock and async active-low reset; inc_i count request;
// inhibit_i suppress counting; we_lo_i/we_hi_i write low [31:0] or high
// [COUNTER_W-1:32] half from wdata_i; count_o registered count.
module csr_wr_unit_counter #(
    parameter int unsigned COUNTER_W = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 inc_i,
    input  logic                 inhibit_i,
    input  logic                 we_lo_i,
    input  logic                 we_hi_i,
    input  logic [31:0]          wdata_i,
    output logic [COUNTER_W-1:0] count_o
);

    localparam int unsigned HI_W = COUNTER_W - 32;

    logic [COUNTER_W-1:0] count_q;

    // A write to either half suppresses the increment for that cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (we_lo_i) begin
            count_q[31:0] <= wdata_i;
        end else if (we_hi_i) begin
            count_q[COUNTER_W-1:32] <= wdata_i[HI_W-1:0];
        end else if (inc_i && !inhibit_i) begin
            count_q <= count_q + COUNTER_W'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/csr_wr_unit.sv
// Write/update side of the machine-mode CSR file with WARL legalisation.
// Ports: clk_i/rst_ni clock and async active-low reset; csr_access_i,
// csr_op_i, csr_addr_i, csr_wdata_i CSR instruction from ID/EX; instr_ret_i
// retire pulse; illegal_csr_write_o combinational illegal-access flag;
// mstatus_o, mie_o, mscratch_o, mepc_o, mtval_o, mtvec_o, mcause_o,
// mcountinhibit_o, mcycle_o, minstret_o stored state for the read mux.
module csr_wr_unit
    import csr_wr_unit_pkg::*;
#(
    parameter bit          PMP_ENABLE  = 1'b0,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0001,
    parameter int unsigned COUNTER_W   = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  csr_access_i,
    input  logic [1:0]            csr_op_i,
    input  logic [CSR_ADDR_W-1:0] csr_addr_i,
    input  logic [CSR_W-1:0]      csr_wdata_i,
    input  logic                  instr_ret_i,
    output logic                  illegal_csr_write_o,
    output status_t               mstatus_o,
    output irqs_t                 mie_o,
    output logic [CSR_W-1:0]      mscratch_o,
    output logic [CSR_W-1:0]      mepc_o,
    output logic [CSR_W-1:0]      mtval_o,
    output logic [CSR_W-1:0]      mtvec_o,
    output logic [5:0]            mcause_o,
    output logic [2:0]            mcountinhibit_o,
    output logic [COUNTER_W-1:0]  mcycle_o,
    output logic [COUNTER_W-1:0]  minstret_o
);

    csr_op_e          csr_op;
    status_t          mstatus_q, mstatus_wr;
    priv_lvl_e        mpp_wr;
    irqs_t            mie_q, mie_wr;
    logic [CSR_W-1:0] mscratch_q, mepc_q, mtval_q, mtvec_q;
    logic [5:0]       mcause_q;
    logic [2:0]       mcountinhibit_q;
    logic [COUNTER_W-1:0] mcycle, minstret;

    logic [CSR_W-1:0] old_val, new_val;
    logic             csr_writable, csr_is_pmp, csr_read_only;
    logic             illegal, csr_we, op_is_rmw;

    assign csr_op = csr_op_e'(csr_op_i);

    // Current value in 32-bit read layout and write-implemented decode.
    always_comb begin
        old_val      = '0;
        csr_writable = 1'b0;
        csr_is_pmp   = 1'b0;
        case (csr_addr_i)
            CSR_MSTATUS:       begin csr_writable = 1'b1; old_val = mstatus_to_word(mstatus_q); end
            CSR_MIE:           begin csr_writable = 1'b1; old_val = mie_to_word(mie_q); end
            CSR_MTVEC:         begin csr_writable = 1'b1; old_val = mtvec_q; end
            CSR_MCOUNTINHIBIT: begin csr_writable = 1'b1; old_val = {29'b0, mcountinhibit_q}; end
            CSR_MSCRATCH:      begin csr_writable = 1'b1; old_val = mscratch_q; end
            CSR_MEPC:          begin csr_writable = 1'b1; old_val = mepc_q; end
            CSR_MCAUSE:        begin csr_writable = 1'b1; old_val = {mcause_q[5], 26'b0, mcause_q[4:0]}; end
            CSR_MTVAL:         begin csr_writable = 1'b1; old_val = mtval_q; end
            CSR_MCYCLE:        begin csr_writable = 1'b1; old_val = mcycle[31:0]; end
            CSR_MCYCLEH:       begin csr_writable = 1'b1; old_val = 32'(mcycle[COUNTER_W-1:32]); end
            CSR_MINSTRET:      begin csr_writable = 1'b1; old_val = minstret[31:0]; end
            CSR_MINSTRETH:     begin csr_writable = 1'b1; old_val = 32'(minstret[COUNTER_W-1:32]); end
            default: begin
                // Unimplemented HPM counters/events accept writes and drop them.
                if (csr_addr_i inside {[CSR_MHPMEVENT3:CSR_MHPMEVENT31],
                                       [CSR_MHPMCOUNTER3:CSR_MHPMCOUNTER31],
                                       [CSR_MHPMCOUNTER3H:CSR_MHPMCOUNTER31H]}) begin
                    csr_writable = 1'b1;
                end
                if (csr_addr_i inside {[CSR_PMPCFG0:CSR_PMPCFG3],
                                       [CSR_PMPADDR0:CSR_PMPADDR15]}) begin
                    csr_is_pmp   = 1'b1;
                    csr_writable = PMP_ENABLE;
                end
            end
        endcase
    end

    // Read/modify/write operand combine.
    always_comb begin
        new_val = csr_wdata_i;
        case (csr_op)
            CSR_OP_SET:   new_val = old_val | csr_wdata_i;
            CSR_OP_CLEAR: new_val = old_val & ~csr_wdata_i;
            default:      new_val = csr_wdata_i;
        endcase
    end

    assign csr_read_only = (csr_addr_i[11:10] == 2'b11);
    assign op_is_rmw     = (csr_op == CSR_OP_SET) || (csr_op == CSR_OP_CLEAR);

    assign illegal = csr_access_i && (csr_op != CSR_OP_READ) &&
                     (csr_read_only || !csr_writable || (csr_is_pmp && !PMP_ENABLE));

    // SET/CLEAR with a zero mask is architecturally a read: no write.
    assign csr_we = csr_access_i && (csr_op != CSR_OP_READ) && !illegal &&
                    !(op_is_rmw && (csr_wdata_i == '0));

    assign illegal_csr_write_o = illegal;

    // mstatus legalisation: unsupported MPP encodings collapse to M-mode.
    always_comb begin
        mpp_wr = priv_lvl_e'(new_val[CSR_MSTATUS_MPP_BIT_HIGH:CSR_MSTATUS_MPP_BIT_LOW]);
        if ((mpp_wr == PRIV_LVL_H) || (mpp_wr == PRIV_LVL_S)) begin
            mpp_wr = PRIV_LVL_M;
        end
        mstatus_wr.mie  = new_val[CSR_MSTATUS_MIE_BIT];
        mstatus_wr.mpie = new_val[CSR_MSTATUS_MPIE_BIT];
        mstatus_wr.mpp  = mpp_wr;
        mstatus_wr.mprv = new_val[CSR_MSTATUS_MPRV_BIT];
        mstatus_wr.tw   = new_val[CSR_MSTATUS_TW_BIT];
    end

    // mie legalisation: only the implemented enable bits are kept.
    always_comb begin
        mie_wr.irq_software = new_val[3];
        mie_wr.irq_timer    = new_val[7];
        mie_wr.irq_external = new_val[11];
        mie_wr.irq_fast     = new_val[30:16];
    end

    // Architectural CSR state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mstatus_q       <= '{mie: 1'b0, mpie: 1'b1, mpp: PRIV_LVL_M, mprv: 1'b0, tw: 1'b0};
            mie_q           <= '0;
            mscratch_q      <= '0;
            mepc_q          <= '0;
            mtval_q         <= '0;
            mtvec_q         <= MTVEC_RESET;
            mcause_q        <= '0;
            mcountinhibit_q <= '0;
        end else if (csr_we) begin
            case (csr_addr_i)
                CSR_MSTATUS:       mstatus_q       <= mstatus_wr;
                CSR_MIE:           mie_q           <= mie_wr;
                CSR_MTVEC:         mtvec_q         <= {new_val[31:8], 6'b0, 2'b01};
                CSR_MCOUNTINHIBIT: mcountinhibit_q <= {new_val[2], 1'b0, new_val[0]};
                CSR_MSCRATCH:      mscratch_q      <= new_val;
                CSR_MEPC:          mepc_q          <= {new_val[31:1], 1'b0};
                CSR_MCAUSE:        mcause_q        <= {new_val[31], new_val[4:0]};
                CSR_MTVAL:         mtval_q         <= new_val;
                default:           ;
            endcase
        end
    end

    // Counters see the inhibit value held before any same-cycle write.
    csr_wr_unit_counter #(.COUNTER_W(COUNTER_W)) u_mcycle (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .inc_i     (1'b1),
        .inhibit_i (mcountinhibit_q[0]),
        .we_lo_i   (csr_we && (csr_addr_i == CSR_MCYCLE)),
        .we_hi_i   (csr_we && (csr_addr_i == CSR_MCYCLEH)),
        .wdata_i   (new_val),
        .count_o   (mcycle)
    );

    csr_wr_unit_counter #(.COUNTER_W(COUNTER_W)) u_minstret (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .inc_i     (instr_ret_i),
        .inhibit_i (mcountinhibit_q[2]),
        .we_lo_i   (csr_we && (csr_addr_i == CSR_MINSTRET)),
        .we_hi_i   (csr_we && (csr_addr_i == CSR_MINSTRETH)),
        .wdata_i   (new_val),
        .count_o   (minstret)
    );

    assign mstatus_o       = mstatus_q;
    assign mie_o           = mie_q;
    assign mscratch_o      = mscratch_q;
    assign mepc_o          = mepc_q;
    assign mtval_o         = mtval_q;
    assign mtvec_o         = mtvec_q;
    assign mcause_o        = mcause_q;
    assign mcountinhibit_o = mcountinhibit_q;
    assign mcycle_o        = mcycle;
    assign minstret_o      = minstret;

endmodule
